// File: rtl/mem_responder.sv
// mem_responder: data-memory responder on the controller's load/store port.
// It captures one request in IDLE and spends WAIT wait states in BUSY.
// The array is written on the edge that enters DONE. On the edge that leaves
// DONE, read data, ready and err are registered, so they are valid together
// for one cycle, WAIT+1 edges after the capture edge.
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rw,
  input  logic [31:0] abda,
  input  logic [31:0] doutstr,
  output logic [31:0] dinldr,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] RW_NOP = 2'b00;
  localparam logic [1:0] RW_RD  = 2'b01;
  localparam logic [1:0] RW_WR  = 2'b10;
  localparam logic [1:0] RW_ILL = 2'b11;

  // Counter preload on capture. WAIT=0 bypasses BUSY, so the value is unused then.
  localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dinldr_q, dinldr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  // Word storage. It has no reset: contents are undefined until written.
  logic [31:0] mem_q [DEPTH];

  // A request is in error if it is misaligned, out of range, or uses the illegal code.
  function automatic logic req_err(input logic [1:0] c, input logic [31:0] a);
    logic misaligned, out_of_range;
    misaligned   = (a[1:0] != 2'b00);
    out_of_range = ((a >> (AW + 2)) != 32'd0);
    return misaligned || out_of_range || (c == RW_ILL);
  endfunction

  // Completion source. With WAIT=0 the write happens on the capture edge itself,
  // so the live inputs are used. Otherwise the captured copy is used.
  logic [1:0]    src_rw;
  logic [31:0]   src_addr;
  logic [31:0]   src_wdata;
  logic [AW-1:0] src_idx;
  logic [AW-1:0] idx_q;
  logic          enter_done;
  logic          mem_we;

  // Select the request that the array write acts on, and detect the edge that enters DONE.
  always_comb begin
    src_rw     = (state_q == S_IDLE) ? rw      : rw_q;
    src_addr   = (state_q == S_IDLE) ? abda    : addr_q;
    src_wdata  = (state_q == S_IDLE) ? doutstr : wdata_q;
    src_idx    = src_addr[AW+1:2];
    idx_q      = addr_q[AW+1:2];
    enter_done = ((state_q == S_IDLE) && (rw != RW_NOP) && (WAIT == 0)) ||
                 ((state_q == S_BUSY) && (cnt_q == 4'd0));
    // Gating on rst_n stops a WAIT=0 write from slipping through while reset is held.
    mem_we     = enter_done && rst_n && (src_rw == RW_WR) &&
                 !req_err(src_rw, src_addr);
  end

  // Next-state logic: capture in IDLE, count in BUSY, and complete when leaving DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dinldr_d = dinldr_q;
    ready_d  = (state_q == S_DONE);
    err_d    = (state_q == S_DONE) && req_err(rw_q, addr_q);

    case (state_q)
      S_IDLE: begin
        if (rw != RW_NOP) begin
          rw_d    = rw;
          addr_d  = abda;
          wdata_d = doutstr;
          if (WAIT == 0) begin
            state_d = S_DONE;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        // rw is ignored here. The next sample happens in the following IDLE cycle.
        state_d = S_IDLE;
        if (rw_q == RW_RD) begin
          dinldr_d = req_err(rw_q, addr_q) ? 32'd0 : mem_q[idx_q];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers. An asynchronous reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rw_q     <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      dinldr_q <= 32'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dinldr_q <= dinldr_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  // Array write on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[src_idx] <= src_wdata;
  end

  assign dinldr = dinldr_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. One instance uses WAIT=2 and one uses WAIT=0.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rw2, rw0;
  logic [31:0] a2, a0, d2, d0;
  logic [31:0] dl2, dl0;
  logic        rdy2, rdy0, er2, er0, bz2, bz0;

  int checks = 0;
  int passed = 0;

  mem_responder #(.DEPTH(256), .WAIT(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .rw(rw2), .abda(a2), .doutstr(d2),
    .dinldr(dl2), .ready(rdy2), .err(er2), .busy(bz2)
  );

  mem_responder #(.DEPTH(256), .WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .rw(rw0), .abda(a0), .doutstr(d0),
    .dinldr(dl0), .ready(rdy0), .err(er0), .busy(bz0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // A WAIT=2 transaction. It returns in the ready cycle, three edges after capture.
  task automatic txn2(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    rw2 = c; a2 = a; d2 = d;
    tick();
    rw2 = 2'b00;
    tick();
    tick();
    chk1("txn_done_no_ready", rdy2, 1'b0);
    tick();
    chk1("txn_ready", rdy2, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rw2 = 2'b00; a2 = '0; d2 = '0;
    rw0 = 2'b00; a0 = '0; d0 = '0;
    #12;
    chk1("rst_ready2", rdy2, 1'b0);
    chk1("rst_err2",   er2,  1'b0);
    chk1("rst_busy2",  bz2,  1'b0);
    chk ("rst_dinldr2", dl2, 32'h0);
    chk1("rst_ready0", rdy0, 1'b0);
    chk ("rst_dinldr0", dl0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // WAIT=0: ready one cycle after capture, and back-to-back every 2 cycles.
    rw0 = 2'b10; a0 = 32'h40; d0 = 32'hCAFEF00D;
    tick();
    rw0 = 2'b00;
    chk1("w0_wr_busy", bz0, 1'b1);
    chk1("w0_wr_noready", rdy0, 1'b0);
    tick();
    chk1("w0_wr_ready", rdy0, 1'b1);
    chk1("w0_wr_err", er0, 1'b0);
    chk1("w0_wr_idle", bz0, 1'b0);
    rw0 = 2'b01; a0 = 32'h40;
    tick();
    chk1("w0_rd_noready", rdy0, 1'b0);
    tick();
    chk1("w0_rd_ready", rdy0, 1'b1);
    chk ("w0_rd_data", dl0, 32'hCAFEF00D);
    tick();
    chk1("w0_b2b_gap", rdy0, 1'b0);
    tick();
    chk1("w0_b2b_ready", rdy0, 1'b1);
    chk ("w0_b2b_data", dl0, 32'hCAFEF00D);
    rw0 = 2'b00;
    tick();

    // WAIT=2: basic write, then read back.
    rw2 = 2'b10; a2 = 32'h10; d2 = 32'hDEADBEEF;
    tick();
    rw2 = 2'b00;
    chk1("w2_busy_rise", bz2, 1'b1);
    chk1("w2_noready_e0", rdy2, 1'b0);
    tick(); tick();
    chk1("w2_noready_e2", rdy2, 1'b0);
    tick();
    chk1("w2_wr_ready", rdy2, 1'b1);
    chk1("w2_wr_err", er2, 1'b0);
    txn2(2'b01, 32'h10, 32'h0);
    chk ("w2_rd_data", dl2, 32'hDEADBEEF);
    chk1("w2_rd_err", er2, 1'b0);

    // Misaligned write, then the old value is still readable. A misaligned read returns 0.
    txn2(2'b10, 32'h13, 32'h12345678);
    chk1("mis_wr_err", er2, 1'b1);
    txn2(2'b01, 32'h10, 32'h0);
    chk ("mis_wr_untouched", dl2, 32'hDEADBEEF);
    chk1("mis_wr_rd_err", er2, 1'b0);
    txn2(2'b01, 32'h11, 32'h0);
    chk ("mis_rd_data", dl2, 32'h0);
    chk1("mis_rd_err", er2, 1'b1);

    // Out-of-range read, and the illegal code.
    txn2(2'b01, 32'h10, 32'h0);
    txn2(2'b01, 32'h400, 32'h0);
    chk ("oor_rd_data", dl2, 32'h0);
    chk1("oor_rd_err", er2, 1'b1);
    txn2(2'b01, 32'h10, 32'h0);
    txn2(2'b11, 32'h10, 32'h0);
    chk1("ill_err", er2, 1'b1);
    chk ("ill_dinldr_kept", dl2, 32'hDEADBEEF);
    txn2(2'b01, 32'h10, 32'h0);
    chk ("ill_mem_kept", dl2, 32'hDEADBEEF);
    chk1("ill_rd_err", er2, 1'b0);

    // Inputs that change during BUSY are ignored.
    txn2(2'b10, 32'h18, 32'h18181818);
    rw2 = 2'b10; a2 = 32'h14; d2 = 32'hA5A5A5A5;
    tick();
    a2 = 32'h18; d2 = 32'hFFFF0000;
    tick(); tick(); tick();
    chk1("chg_ready", rdy2, 1'b1);
    chk1("chg_err", er2, 1'b0);
    rw2 = 2'b00;
    tick();
    txn2(2'b01, 32'h14, 32'h0);
    chk ("chg_orig_written", dl2, 32'hA5A5A5A5);
    txn2(2'b01, 32'h18, 32'h0);
    chk ("chg_new_ignored", dl2, 32'h18181818);

    // A reset in mid-request aborts the write.
    txn2(2'b10, 32'h20, 32'h20202020);
    txn2(2'b01, 32'h18, 32'h0);
    rw2 = 2'b10; a2 = 32'h20; d2 = 32'hBAD0BAD0;
    tick();
    rw2 = 2'b00;
    tick();
    chk1("abort_busy_before", bz2, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("abort_ready", rdy2, 1'b0);
    chk1("abort_busy", bz2, 1'b0);
    chk1("abort_err", er2, 1'b0);
    chk ("abort_dinldr", dl2, 32'h0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    txn2(2'b01, 32'h20, 32'h0);
    chk ("abort_no_write", dl2, 32'h20202020);
    chk1("abort_rd_err", er2, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
